// File: rtl/ifq_pop_stage.sv
// Pop stage behind the instruction fetch queue: issues credit-limited pops,
// buffers the one-cycle-late FIFO data in two slots and hands entries to decode.
module ifq_pop_stage #(
    parameter int FIFOWIDE = 32,
    parameter int SEQWIDE  = 8
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                FifoEmpty,
    input  logic [FIFOWIDE-1:0] FifoDout,
    output logic                FifoRable,
    output logic                FifoClean,
    input  logic                Flush,
    output logic                OutValid,
    output logic [FIFOWIDE-1:0] OutData,
    output logic [SEQWIDE-1:0]  OutSeq,
    input  logic                OutReady
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      in_flight;
    logic                      head, tail;
    logic [1:0][FIFOWIDE-1:0]  slot;
    logic [SEQWIDE-1:0]        seq;
    logic                      pop;
    logic [1:0]                count;
    logic [1:0]                credit;

    assign count    = state_q;
    assign OutValid = (state_q != EMPTY);
    assign pop      = OutValid && OutReady;

    // Occupancy once this cycle settles; a new pop is allowed only if its data
    // will still find a free slot when it lands next cycle.
    assign credit    = count + {1'b0, in_flight} - {1'b0, pop};
    assign FifoRable = Rest && !Flush && !FifoEmpty && (credit < 2'd2);
    assign FifoClean = Flush;

    assign OutData = slot[head];
    assign OutSeq  = seq;

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = EMPTY;
        end else begin
            case ({in_flight, pop})
                2'b10: begin
                    case (state_q)
                        EMPTY:   state_d = ONE;
                        ONE:     state_d = TWO;
                        default: state_d = state_q;
                    endcase
                end
                2'b01: begin
                    case (state_q)
                        ONE:     state_d = EMPTY;
                        TWO:     state_d = ONE;
                        default: state_d = state_q;
                    endcase
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            in_flight <= 1'b0;
            head      <= 1'b0;
            tail      <= 1'b0;
            slot      <= '0;
            seq       <= '0;
        end else if (Flush) begin
            // Data returning next cycle is dropped because in_flight clears here.
            in_flight <= 1'b0;
            head      <= 1'b0;
            tail      <= 1'b0;
            seq       <= '0;
        end else begin
            in_flight <= FifoRable;
            if (in_flight) begin
                slot[tail] <= FifoDout;
                tail       <= ~tail;
            end
            if (pop) begin
                head <= ~head;
                seq  <= seq + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifq_pop_stage.sv
// Randomised bench for ifq_pop_stage: a queue-based FIFO model feeds the DUT and
// a queue-based reference of the delivery buffer predicts every output.
module tb_ifq_pop_stage;

    logic        Clk = 1'b0;
    logic        Rest;
    logic        FifoEmpty;
    logic [31:0] FifoDout;
    logic        FifoRable;
    logic        FifoClean;
    logic        Flush;
    logic        OutValid;
    logic [31:0] OutData;
    logic [7:0]  OutSeq;
    logic        OutReady;

    ifq_pop_stage #(.FIFOWIDE(32), .SEQWIDE(8)) dut (
        .Clk      (Clk),
        .Rest     (Rest),
        .FifoEmpty(FifoEmpty),
        .FifoDout (FifoDout),
        .FifoRable(FifoRable),
        .FifoClean(FifoClean),
        .Flush    (Flush),
        .OutValid (OutValid),
        .OutData  (OutData),
        .OutSeq   (OutSeq),
        .OutReady (OutReady)
    );

    always #5 Clk = ~Clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // FIFO contents not yet popped, and the reference delivery buffer.
    logic [31:0] fifo_q[$];
    logic [31:0] buf_q[$];
    int          inflight;
    int          seq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic step(input logic rdy, input logic fl);
        logic [31:0] cur;
        int          evalid, epop, erable;
        FifoEmpty = (fifo_q.size() == 0);
        OutReady  = rdy;
        Flush     = fl;
        @(negedge Clk);
        evalid = (buf_q.size() != 0);
        epop   = evalid && rdy;
        erable = Rest && !fl && !FifoEmpty && ((buf_q.size() + inflight - epop) < 2);
        chk("out_valid", OutValid, evalid);
        if (evalid) begin
            chk("out_data", OutData, buf_q[0]);
            chk("out_seq", OutSeq, seq);
        end
        chk("fifo_rable", FifoRable, erable);
        chk("fifo_clean", FifoClean, fl);
        cur = FifoDout;
        @(posedge Clk);
        #1;
        if (fl) begin
            buf_q.delete();
            inflight = 0;
            seq      = 0;
            fifo_q.delete();
        end else begin
            if (epop) begin
                void'(buf_q.pop_front());
                seq = (seq + 1) % 256;
            end
            if (inflight != 0) buf_q.push_back(cur);
            inflight = erable;
        end
        if (erable != 0) FifoDout = fifo_q.pop_front();
        else             FifoDout = $urandom();
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back($urandom());
    endtask

    initial begin
        Rest      = 1'b0;
        Flush     = 1'b0;
        OutReady  = 1'b0;
        FifoDout  = 32'hdead_beef;
        inflight  = 0;
        seq       = 0;
        fifo_q.push_back(32'h11);
        fifo_q.push_back(32'h22);
        fifo_q.push_back(32'h33);
        FifoEmpty = 1'b0;
        @(posedge Clk);
        #1;
        chk("rst_valid", OutValid, 0);
        chk("rst_data", OutData, 0);
        chk("rst_seq", OutSeq, 0);
        chk("rst_rable", FifoRable, 0);
        Rest = 1'b1;

        // stream of three, then drain
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);

        // backpressure: fill to two, hold, then release
        load(4);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);

        // capture and pop together while one entry is held
        load(6);
        step(1'b1, 1'b0); step(1'b1, 1'b0);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b0); step(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);

        // flush while a read is in flight
        load(5);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        load(3);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);

        // sequence wrap
        load(260);
        for (int i = 0; i < 264; i++) step(1'b1, 1'b0);

        // asynchronous reset with two entries held
        load(4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        #2 Rest = 1'b0;
        #1;
        chk("arst_valid", OutValid, 0);
        chk("arst_data", OutData, 0);
        chk("arst_seq", OutSeq, 0);
        chk("arst_rable", FifoRable, 0);
        buf_q.delete();
        inflight = 0;
        seq      = 0;
        FifoDout = $urandom();
        @(posedge Clk);
        #1;
        chk("arst_hold_rable", FifoRable, 0);
        Rest = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) load($urandom_range(1, 4));
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ifq_pop_stage.md
Name: ifq_pop_stage

Overview:
- Consumer stage directly downstream of the 17-entry instruction fetch queue FIFO.
- Pops entries from the FIFO, which returns registered read data one cycle after the pop request.
- Holds popped entries in a 2-entry output buffer and presents them to decode with a valid/ready handshake.
- Sustains one entry per cycle, never overruns its buffer, tags every delivered entry with a sequence number, and propagates pipeline flush to the FIFO.

Parameters:
- FIFOWIDE, 32, width of one queue entry; must match the FIFO instance.
- SEQWIDE, 8, width of the delivered-entry sequence counter.

Ports:
- Clk  input  1  clock, rising edge.
- Rest  input  1  reset, asynchronous, active-low.
- FifoEmpty  input  1  FIFO empty flag.
- FifoDout  input  FIFOWIDE  FIFO registered read data; valid the cycle after FifoRable=1.
- FifoRable  output  1  FIFO pop request; one entry per cycle.
- FifoClean  output  1  FIFO clear; combinationally equal to Flush.
- Flush  input  1  pipeline flush from backend/branch resolution.
- OutValid  output  1  OutData holds a valid entry.
- OutData  output  FIFOWIDE  head entry of the output buffer.
- OutSeq  output  SEQWIDE  sequence number of the head entry.
- OutReady  input  1  decode accepts the head entry this cycle.

Behaviour:
- Reset (Rest low, asynchronous):
  - Buffer count=0, InFlight=0, head/tail pointers=0, both buffer slots=0, sequence counter=0.
  - OutValid=0, OutData=0, OutSeq=0.
  - FifoRable is forced 0 while Rest is low, independent of FifoEmpty.
- Internal state:
  - Count in {0,1,2}; states EMPTY, ONE, TWO.
  - InFlight bit: a pop was issued last cycle and its data arrives on FifoDout this cycle.
- Pop = OutValid && OutReady. OutValid = (count != 0).
- FifoRable = Rest && !Flush && !FifoEmpty && ((count + InFlight - Pop) < 2). The arithmetic is 2-bit unsigned and never underflows, because Pop implies count ≥ 1.
- Each clock edge without Flush:
  - InFlight <= FifoRable.
  - If InFlight, FifoDout is written to the tail slot and the tail pointer toggles.
  - If Pop, the head pointer toggles and the sequence counter increments.
  - count <= count + InFlight - Pop.
  - EMPTY->ONE on capture without pop.
  - ONE->TWO on capture without pop.
  - TWO->ONE on pop; no capture can occur in TWO (credit rule).
  - ONE->EMPTY on pop without capture.
  - Capture and pop in the same cycle: state unchanged; FIFO order preserved.
- Latency: FifoRable high at cycle N -> entry visible on OutData/OutValid at cycle N+2.
- Throughput: with OutReady held high and FIFO non-empty, steady state is count=1, InFlight=1, one entry delivered per cycle.
- OutSeq = sequence counter value. It increments per accepted entry and wraps modulo 2^SEQWIDE (255 -> 0 for the default).
- Backpressure: OutReady low holds OutData/OutSeq stable while OutValid=1. A valid entry is never dropped or reordered.
- Flush, any cycle:
  - FifoClean=1 and FifoRable=0 that cycle.
  - At the edge: count=0, pointers=0, InFlight=0, sequence counter=0.
  - Data returning on FifoDout the cycle after a flush edge is discarded, because InFlight is already 0.
  - OutValid=0 from the cycle after Flush.
  - Pop coinciding with Flush has no effect.
- FifoEmpty becoming 1 with InFlight=1: the in-flight entry is still captured. FifoEmpty only gates new pops.
- Reset mid-operation: all state clears immediately; the in-flight entry is lost.

Test Plan:
- Reset then stream: FIFO preloaded 0x11,0x22,0x33, OutReady=1 -> FifoRable at cycles 0,1,2; OutData 0x11,0x22,0x33 with OutSeq 0,1,2 at cycles 2,3,4; OutValid=0 at cycle 5.
- Backpressure: 4 entries, OutReady=0 -> exactly 2 pops issued, count=2, FifoRable stays 0, OutData=entry0 stable. Release OutReady -> remaining entries delivered in order, no loss or duplication.
- Capture+pop same cycle in ONE: OutReady toggling 1,0,1,1 -> data order intact and count never exceeds 2 (assertion).
- Flush with in-flight read: Flush in the cycle after FifoRable=1 -> FifoClean=1 that cycle, returning FifoDout ignored, OutValid=0 next cycle, next delivered entry has OutSeq=0.
- Sequence wrap: 257 entries accepted -> OutSeq 255 then 0 then 1.
- Async reset with count=2: Rest low between edges -> OutValid/OutData/OutSeq=0 immediately, FifoRable=0 while Rest is low.
